// File: rtl/jts16_sndcmd_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : jts16_sndcmd_tx                                            |
// | Description : Main-CPU sound command transmitter. With                   |
// |               JTS16_SNDCMD_FIFO_EN defined, bytes are queued and handed  |
// |               over one at a time with an irqn/ack handshake; otherwise a |
// |               single latch with a fixed-width irqn pulse.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module jts16_sndcmd_tx #(
    parameter int AW   = 2,
    parameter int IRQW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_we,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    latch,
    output logic          irqn,
    input  logic          ack,
    input  logic          ovf_clr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow
);
    localparam logic [7:0] c_irqw = 8'(IRQW);

    logic [7:0] r_latch;
    logic [7:0] r_cnt;
    logic       r_irqn;

    assign latch = r_latch;
    assign irqn  = r_irqn;

`ifdef JTS16_SNDCMD_FIFO_EN
    localparam int unsigned c_depth = 1 << AW;
    localparam logic [AW:0] c_one   = 1;
    localparam logic [1:0]  c_idle  = 2'd0;
    localparam logic [1:0]  c_req   = 2'd1;
    localparam logic [1:0]  c_rel   = 2'd2;

    logic [7:0]  r_mem [c_depth];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [1:0]  r_state;
    logic        r_ack_l;
    logic        r_got_ack;
    logic        r_overflow;

    logic [AW:0] w_level;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_ack_rise;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_level    = r_wr_ptr - r_rd_ptr;
    assign w_full     = w_level[AW];
    assign w_empty    = (w_level == '0);
    assign w_ack_rise = ack & ~r_ack_l;
    assign w_pop      = ~w_empty & ((r_state == c_idle) | ((r_state == c_rel) & ~ack));
    assign w_push     = cpu_we & (~w_full | w_pop);

    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = w_level;
    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= cpu_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ack_l    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_ack_l <= ack;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_one;
            end
            if (ovf_clr) begin
                r_overflow <= 1'b0;
            end else if (cpu_we && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_idle;
            r_latch   <= 8'h00;
            r_irqn    <= 1'b1;
            r_cnt     <= 8'd0;
            r_got_ack <= 1'b0;
        end else if (w_pop) begin
            r_latch   <= r_mem[r_rd_ptr[AW-1:0]];
            r_irqn    <= 1'b0;
            r_cnt     <= 8'd0;
            r_got_ack <= 1'b0;
            r_state   <= c_req;
        end else begin
            case (r_state)
                c_req: begin
                    if (r_cnt < c_irqw) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    if (w_ack_rise) begin
                        r_got_ack <= 1'b1;
                    end
                    // got_ack is registered, so release lands one cycle after the rising edge
                    if (r_got_ack && (r_cnt >= c_irqw - 8'd1)) begin
                        r_irqn    <= 1'b1;
                        r_got_ack <= 1'b0;
                        r_state   <= c_rel;
                    end
                end
                c_rel: begin
                    if (!ack) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end
`else
    logic w_unused;

    assign full     = 1'b0;
    assign empty    = 1'b1;
    assign level    = '0;
    assign overflow = 1'b0;
    assign w_unused = &{1'b0, ack, ovf_clr};

    // Every write restarts a fixed irqn pulse; the sound CPU ack plays no part.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_latch <= 8'h00;
            r_irqn  <= 1'b1;
            r_cnt   <= 8'd0;
        end else if (cpu_we) begin
            r_latch <= cpu_din;
            r_irqn  <= 1'b0;
            r_cnt   <= c_irqw - 8'd1;
        end else if (!r_irqn) begin
            if (r_cnt == 8'd0) begin
                r_irqn <= 1'b1;
            end else begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_jts16_sndcmd_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_jts16_sndcmd_tx                                         |
// | Description : Self-checking bench for jts16_sndcmd_tx (both builds).     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_jts16_sndcmd_tx;
    localparam int AW    = 2;
    localparam int IRQW  = 8;
    localparam int DEPTH = 1 << AW;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        cpu_we  = 1'b0;
    logic [7:0]  cpu_din = 8'h00;
    logic        ack     = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [7:0]  latch;
    logic        irqn;
    logic        full;
    logic        empty;
    logic [AW:0] level;
    logic        overflow;

    int n_pass  = 0;
    int n_total = 0;
    bit run     = 1'b0;

    jts16_sndcmd_tx #(.AW(AW), .IRQW(IRQW)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_we   (cpu_we),
        .cpu_din  (cpu_din),
        .latch    (latch),
        .irqn     (irqn),
        .ack      (ack),
        .ovf_clr  (ovf_clr),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: edge-numbered timing rules and a byte queue
    logic [7:0] q[$];
    logic [7:0] m_latch    = 8'h00;
    logic       m_irqn     = 1'b1;
    logic       m_ovf      = 1'b0;
    logic       m_wait_low = 1'b0;
    logic       ack_prev   = 1'b0;
    int         edge_n     = 0;
    int         fall_e     = 0;
    int         ack_e      = -1;
    int         rel_e      = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_latch    = 8'h00;
            m_irqn     = 1'b1;
            m_ovf      = 1'b0;
            m_wait_low = 1'b0;
            ack_prev   = 1'b0;
            ack_e      = -1;
            rel_e      = edge_n;
        end else begin
            edge_n++;
`ifdef JTS16_SNDCMD_FIFO_EN
            if (!m_irqn) begin
                // Release needs IRQW low cycles and an ack rise seen at an earlier edge
                if (ack_e >= 0 && edge_n >= fall_e + IRQW) begin
                    m_irqn     = 1'b1;
                    m_wait_low = 1'b1;
                end else if (ack && !ack_prev && ack_e < 0) begin
                    ack_e = edge_n;
                end
            end else if (!m_wait_low || !ack) begin
                m_wait_low = 1'b0;
                if (q.size() > 0) begin
                    m_latch = q.pop_front();
                    m_irqn  = 1'b0;
                    fall_e  = edge_n;
                    ack_e   = -1;
                end
            end
            if (cpu_we) begin
                if (q.size() < DEPTH) q.push_back(cpu_din);
                else m_ovf = 1'b1;
            end
            if (ovf_clr) m_ovf = 1'b0;
            ack_prev = ack;
`else
            if (cpu_we) begin
                m_latch = cpu_din;
                rel_e   = edge_n + IRQW;
            end
            m_irqn = (edge_n >= rel_e);
`endif
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("latch",    latch,    m_latch);
            chk("irqn",     irqn,     m_irqn);
            chk("level",    level,    q.size());
            chk("full",     full,     (q.size() == DEPTH));
            chk("empty",    empty,    (q.size() == 0));
            chk("overflow", overflow, m_ovf);
        end
    end

    int n;
    int ack_hold = 0;

    task automatic handshake();
        int c;
        c   = 0;
        ack = 1'b1;
        while (irqn === 1'b0 && c < 100) begin
            tick(1);
            c++;
        end
        ack = 1'b0;
        chk("hs_release", irqn, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        run   = 1'b1;
        chk("rst_latch", latch, 8'h00);
        chk("rst_irqn",  irqn,  1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_level", level, 0);
        tick(2);

`ifdef JTS16_SNDCMD_FIFO_EN
        // single write, late ack
        cpu_we = 1'b1; cpu_din = 8'hA5; tick(1);
        cpu_we = 1'b0; tick(1);
        chk("a5_latch", latch, 8'hA5);
        chk("a5_irqn",  irqn,  1'b0);
        tick(15);
        ack = 1'b1; tick(1);
        chk("a5_hold", irqn, 1'b0);
        tick(1);
        chk("a5_rel", irqn, 1'b1);
        tick(1); ack = 1'b0; tick(2);
        chk("a5_level", level, 0);

        // early ack keeps irqn low exactly IRQW cycles
        cpu_we = 1'b1; cpu_din = 8'hB6; tick(1);
        cpu_we = 1'b0; tick(1);
        chk("early_fall", irqn, 1'b0);
        tick(1);
        ack = 1'b1; n = 1;
        while (irqn === 1'b0 && n < 50) begin
            tick(1);
            n++;
        end
        chk("early_width", n, IRQW);
        ack = 1'b0; tick(2);

        // three back-to-back writes
        cpu_we = 1'b1;
        cpu_din = 8'h01; tick(1);
        cpu_din = 8'h02; tick(1);
        cpu_din = 8'h03; tick(1);
        cpu_we = 1'b0;
        chk("seq_level", level, 2);
        chk("seq_01", latch, 8'h01);
        handshake(); tick(1);
        chk("seq_02", latch, 8'h02);
        chk("seq_02_irqn", irqn, 1'b0);
        handshake(); tick(1);
        chk("seq_03", latch, 8'h03);
        handshake(); tick(1);
        chk("seq_idle", irqn, 1'b1);
        chk("seq_empty", empty, 1'b1);

        // overflow with no ack
        for (int i = 0; i < 6; i++) begin
            cpu_we = 1'b1; cpu_din = 8'h40 + 8'(i); tick(1);
        end
        cpu_we = 1'b0;
        chk("ovf_latch", latch, 8'h40);
        chk("ovf_level", level, 4);
        chk("ovf_full",  full,  1'b1);
        chk("ovf_flag",  overflow, 1'b1);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 1'b0);
`else
        // single latch: second write overrides and restarts the pulse
        cpu_we = 1'b1; cpu_din = 8'h11; tick(1);
        cpu_we = 1'b0;
        chk("nf_latch11", latch, 8'h11);
        chk("nf_fall",    irqn,  1'b0);
        ack = 1'b1; tick(3); ack = 1'b0;
        cpu_we = 1'b1; cpu_din = 8'h22; tick(1);
        cpu_we = 1'b0;
        chk("nf_latch22", latch, 8'h22);
        chk("nf_low",     irqn,  1'b0);
        n = 0;
        while (irqn === 1'b0 && n < 50) begin
            tick(1);
            n++;
        end
        chk("nf_width", n, IRQW);
        chk("nf_full",  full, 1'b0);
        cpu_we = 1'b1; cpu_din = 8'h77; tick(1);
        cpu_we = 1'b0;
`endif

        // asynchronous reset in the middle of a request
        chk("mid_req", irqn, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_irqn",  irqn,  1'b1);
        chk("arst_latch", latch, 8'h00);
        chk("arst_level", level, 0);
        tick(1);
        rst_n = 1'b1;
        tick(10);
        chk("arst_quiet", irqn, 1'b1);

        // randomized traffic with a sound-CPU-like ack responder
        for (int i = 0; i < 4000; i++) begin
            cpu_we  = ($urandom_range(0, 3) == 0);
            cpu_din = 8'($urandom);
            ovf_clr = ($urandom_range(0, 39) == 0);
            if (ack_hold > 0) begin
                ack = 1'b1;
                ack_hold--;
            end else if ((irqn === 1'b0 && $urandom_range(0, 4) == 0) || $urandom_range(0, 29) == 0) begin
                ack      = 1'b1;
                ack_hold = $urandom_range(0, 3);
            end else begin
                ack = 1'b0;
            end
            rst_n = ($urandom_range(0, 999) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        cpu_we = 1'b0;
        ack = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
